// File: rtl/vga_sprite_engine_if.sv
// Sprite attribute write port. The host side (master) loads shadow attributes
// into the renderer (slave); they take effect at the next frame tick.
interface vga_sprite_engine_if #(
    parameter int SEL_W   = 2,
    parameter int FRAME_W = 2
);
    logic               cfg_we;
    logic [SEL_W-1:0]   cfg_sel;
    logic [9:0]         cfg_x;
    logic [9:0]         cfg_y;
    logic [FRAME_W-1:0] cfg_frame;
    logic               cfg_vis;

    modport master (output cfg_we, cfg_sel, cfg_x, cfg_y, cfg_frame, cfg_vis);
    modport slave  (input  cfg_we, cfg_sel, cfg_x, cfg_y, cfg_frame, cfg_vis);
endinterface

// File: rtl/vga_sprite_engine.sv
// Multi-sprite compositor: per-sprite hit test, priority pick, shared RGB565 ROM, 2-clk pipeline.
// Optional per-sprite frame animation is enabled with `define SPRITE_ANIM_EN.
module vga_sprite_hit #(
    parameter int SPR_W_LOG2 = 4,
    parameter int SPR_H_LOG2 = 4,
    parameter int FRAME_W    = 2,
    parameter int H_ACTIVE   = 640,
    parameter int V_ACTIVE   = 480,
    localparam int ADDR_WIDTH = FRAME_W + SPR_H_LOG2 + SPR_W_LOG2
) (
    input  logic [9:0]            h,
    input  logic [9:0]            v,
    input  logic [9:0]            x,
    input  logic [9:0]            y,
    input  logic [FRAME_W-1:0]    frame,
    input  logic                  vis,
    output logic                  hit,
    output logic [ADDR_WIDTH-1:0] addr
);
    localparam logic [10:0] H_LIM = 11'(H_ACTIVE);
    localparam logic [10:0] V_LIM = 11'(V_ACTIVE);
    localparam logic [10:0] W_LIM = 11'(2 ** SPR_W_LOG2);
    localparam logic [10:0] S_LIM = 11'(2 ** SPR_H_LOG2);

    logic [10:0] dx, dy;

    // 11-bit offsets: a sprite hanging past the right/bottom edge clips, never wraps
    always_comb begin
        dx   = {1'b0, h} - {1'b0, x};
        dy   = {1'b0, v} - {1'b0, y};
        hit  = vis && (h >= x) && (v >= y) && (dx < W_LIM) && (dy < S_LIM) &&
               ({1'b0, h} < H_LIM) && ({1'b0, v} < V_LIM);
        addr = {frame, dy[SPR_H_LOG2-1:0], dx[SPR_W_LOG2-1:0]};
    end
endmodule

module vga_sprite_engine #(
    parameter int          NUM_SPRITES = 4,
    parameter int          SPR_W_LOG2  = 4,
    parameter int          SPR_H_LOG2  = 4,
    parameter int          FRAME_W     = 2,
    parameter int          H_ACTIVE    = 640,
    parameter int          V_ACTIVE    = 480,
    parameter logic [15:0] KEY_COLOR   = 16'hF81F,
    parameter logic [15:0] BG_COLOR    = 16'h0000,
    parameter int          ANIM_DIV    = 8,
    localparam int ADDR_WIDTH = FRAME_W + SPR_H_LOG2 + SPR_W_LOG2,
    localparam int SEL_W      = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [9:0]            hcount_in,
    input  logic [9:0]            vcount_in,
    input  logic                  bright_in,
    input  logic                  hsync_in,
    input  logic                  vsync_in,
    vga_sprite_engine_if.slave    cfg,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    input  logic [15:0]           rom_data,
    output logic [7:0]            vga_r,
    output logic [7:0]            vga_g,
    output logic [7:0]            vga_b,
    output logic                  hsync_out,
    output logic                  vsync_out,
    output logic                  bright_out,
    output logic                  frame_tick
);
    localparam logic [10:0] V_LIM = 11'(V_ACTIVE);

    if (NUM_SPRITES < 1 || NUM_SPRITES > 8 || ANIM_DIV < 1) begin : g_bad_param
        $error("vga_sprite_engine: NUM_SPRITES must be 1..8 and ANIM_DIV >= 1");
    end

    typedef struct packed {
        logic [9:0]         x;
        logic [9:0]         y;
        logic [FRAME_W-1:0] frame;
        logic               vis;
    } attr_t;

    attr_t shadow_d [NUM_SPRITES];
    attr_t shadow_q [NUM_SPRITES];
    attr_t active_d [NUM_SPRITES];
    attr_t active_q [NUM_SPRITES];

    logic [NUM_SPRITES-1:0]                 wr_sel, hit;
    logic [NUM_SPRITES-1:0][FRAME_W-1:0]    eff_frame;
    logic [NUM_SPRITES-1:0][ADDR_WIDTH-1:0] spr_addr;

    logic                  vblank_d, vblank_q, vblank2_q;
    logic [ADDR_WIDTH-1:0] rom_addr_d, rom_addr_q;
    logic                  hit_d;
    logic [2:1]            vld_pipe_q, hs_pipe_q, vs_pipe_q, hit_pipe_q;
    logic [15:0]           pix;

    assign vblank_d   = ({1'b0, vcount_in} >= V_LIM);
    assign frame_tick = vblank_q & ~vblank2_q;

    // Copy reads shadow_q, so a write landing on the tick cycle waits one frame
    always_comb begin
        shadow_d = shadow_q;
        active_d = active_q;
        for (int i = 0; i < NUM_SPRITES; i++) begin
            wr_sel[i] = cfg.cfg_we && (cfg.cfg_sel == SEL_W'(i));
            if (frame_tick) active_d[i] = shadow_q[i];
            if (wr_sel[i])  shadow_d[i] = '{x: cfg.cfg_x, y: cfg.cfg_y,
                                            frame: cfg.cfg_frame, vis: cfg.cfg_vis};
        end
    end

`ifdef SPRITE_ANIM_EN
    localparam int PH_W = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;

    logic [PH_W-1:0]        phase_d [NUM_SPRITES];
    logic [PH_W-1:0]        phase_q [NUM_SPRITES];
    logic [FRAME_W-1:0]     anim_d  [NUM_SPRITES];
    logic [FRAME_W-1:0]     anim_q  [NUM_SPRITES];
    logic [NUM_SPRITES-1:0] reload_d, reload_q;

    // A frame write restarts the phase; the new base frame loads with the attributes at the tick
    always_comb begin
        phase_d  = phase_q;
        anim_d   = anim_q;
        reload_d = reload_q;
        for (int i = 0; i < NUM_SPRITES; i++) begin
            if (frame_tick) begin
                if (reload_q[i]) begin
                    anim_d[i]   = shadow_q[i].frame;
                    reload_d[i] = 1'b0;
                    phase_d[i]  = '0;
                end else if (phase_q[i] == PH_W'(ANIM_DIV - 1)) begin
                    phase_d[i] = '0;
                    anim_d[i]  = (anim_q[i] == '1) ? active_q[i].frame : anim_q[i] + 1'b1;
                end else begin
                    phase_d[i] = phase_q[i] + 1'b1;
                end
            end
            if (wr_sel[i]) begin
                phase_d[i]  = '0;
                reload_d[i] = 1'b1;
            end
            eff_frame[i] = anim_q[i];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reload_q <= '0;
            for (int i = 0; i < NUM_SPRITES; i++) begin
                phase_q[i] <= '0;
                anim_q[i]  <= '0;
            end
        end else begin
            reload_q <= reload_d;
            phase_q  <= phase_d;
            anim_q   <= anim_d;
        end
    end
`else
    always_comb begin
        for (int i = 0; i < NUM_SPRITES; i++) eff_frame[i] = active_q[i].frame;
    end
`endif

    for (genvar i = 0; i < NUM_SPRITES; i++) begin : g_spr
        vga_sprite_hit #(
            .SPR_W_LOG2(SPR_W_LOG2), .SPR_H_LOG2(SPR_H_LOG2), .FRAME_W(FRAME_W),
            .H_ACTIVE(H_ACTIVE), .V_ACTIVE(V_ACTIVE)
        ) u_hit (
            .h(hcount_in), .v(vcount_in), .x(active_q[i].x), .y(active_q[i].y),
            .frame(eff_frame[i]), .vis(active_q[i].vis),
            .hit(hit[i]), .addr(spr_addr[i])
        );
    end

    // Descending scan so the lowest-index hit wins; no hit keeps the last address
    always_comb begin
        hit_d      = 1'b0;
        rom_addr_d = rom_addr_q;
        for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
            if (hit[i]) begin
                hit_d      = 1'b1;
                rom_addr_d = spr_addr[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vblank_q   <= 1'b0;
            vblank2_q  <= 1'b0;
            rom_addr_q <= '0;
            vld_pipe_q <= '0;
            hs_pipe_q  <= '0;
            vs_pipe_q  <= '0;
            hit_pipe_q <= '0;
            for (int i = 0; i < NUM_SPRITES; i++) begin
                shadow_q[i] <= '0;
                active_q[i] <= '0;
            end
        end else begin
            vblank_q   <= vblank_d;
            vblank2_q  <= vblank_q;
            rom_addr_q <= rom_addr_d;
            vld_pipe_q <= {vld_pipe_q[1], bright_in};
            hs_pipe_q  <= {hs_pipe_q[1], hsync_in};
            vs_pipe_q  <= {vs_pipe_q[1], vsync_in};
            hit_pipe_q <= {hit_pipe_q[1], hit_d};
            shadow_q   <= shadow_d;
            active_q   <= active_d;
        end
    end

    assign rom_addr   = rom_addr_q;
    assign bright_out = vld_pipe_q[2];
    assign hsync_out  = hs_pipe_q[2];
    assign vsync_out  = vs_pipe_q[2];

    // rom_data lines up with stage-2 control; a keyed winner pixel shows background
    always_comb begin
        pix   = (hit_pipe_q[2] && (rom_data != KEY_COLOR)) ? rom_data : BG_COLOR;
        vga_r = 8'h00;
        vga_g = 8'h00;
        vga_b = 8'h00;
        if (vld_pipe_q[2]) begin
            vga_r = {pix[15:11], pix[15:13]};
            vga_g = {pix[10:5],  pix[10:9]};
            vga_b = {pix[4:0],   pix[4:2]};
        end
    end
endmodule

// File: tb/tb_vga_sprite_engine.sv
// Directed bench for vga_sprite_engine: hand-computed ROM addresses, colours,
// attribute double-buffering, priority, edge clipping and async reset.
module tb_vga_sprite_engine;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [9:0] hcount_in = '0, vcount_in = '0;
    logic       bright_in = 1'b0, hsync_in = 1'b0, vsync_in = 1'b0;
    logic [9:0] rom_addr;
    logic [15:0] rom_data = '0;
    logic [15:0] rom_val = '0;
    logic [7:0] vga_r, vga_g, vga_b;
    logic       hsync_out, vsync_out, bright_out, frame_tick;
    int         n_chk = 0, n_fail = 0;

    vga_sprite_engine_if #(.SEL_W(2), .FRAME_W(2)) cfg_if ();

    vga_sprite_engine dut (
        .clk(clk), .rst_n(rst_n),
        .hcount_in(hcount_in), .vcount_in(vcount_in),
        .bright_in(bright_in), .hsync_in(hsync_in), .vsync_in(vsync_in),
        .cfg(cfg_if),
        .rom_addr(rom_addr), .rom_data(rom_data),
        .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
        .hsync_out(hsync_out), .vsync_out(vsync_out),
        .bright_out(bright_out), .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    // Synchronous ROM: data one clock after address
    always @(posedge clk) rom_data <= rom_val;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic px(input int h, input int v);
        hcount_in = 10'(h);
        vcount_in = 10'(v);
    endtask

    task automatic set_cfg(input int sel, input int x, input int y, input int f, input bit vis);
        cfg_if.cfg_sel   = 2'(sel);
        cfg_if.cfg_x     = 10'(x);
        cfg_if.cfg_y     = 10'(y);
        cfg_if.cfg_frame = 2'(f);
        cfg_if.cfg_vis   = vis;
    endtask

    task automatic wr_cfg(input int sel, input int x, input int y, input int f, input bit vis);
        set_cfg(sel, x, y, f, vis);
        cfg_if.cfg_we = 1'b1;
        step(1);
        cfg_if.cfg_we = 1'b0;
    endtask

    // Enter vblank for two clocks; optionally assert cfg_we on the tick cycle
    task automatic vblank(input bit wr_on_tick);
        vcount_in = 10'd480;
        step(1);
        chk("frame_tick_hi", frame_tick, 1);
        cfg_if.cfg_we = wr_on_tick;
        step(1);
        chk("frame_tick_lo", frame_tick, 0);
        cfg_if.cfg_we = 1'b0;
        vcount_in = 10'd0;
        step(1);
    endtask

    task automatic colour_at(input string tag, input int h, input int v, input logic [23:0] exp);
        px(h, v);
        step(2);
        chk(tag, {vga_r, vga_g, vga_b}, {8'h00, exp});
    endtask

    initial begin
        cfg_if.cfg_we = 1'b0;
        set_cfg(0, 0, 0, 0, 1'b0);

        // Held in reset
        step(2);
        chk("rst_rgb", {vga_r, vga_g, vga_b}, 0);
        chk("rst_addr", rom_addr, 0);
        chk("rst_sync", {hsync_out, vsync_out, bright_out, frame_tick}, 0);
        rst_n = 1'b1;

        // No sprites visible: background only
        bright_in = 1'b1;
        rom_val   = 16'hF800;
        colour_at("bg_after_rst", 0, 0, 24'h000000);
        chk("bright_out", bright_out, 1);

        // Single sprite, address corners
        wr_cfg(0, 100, 50, 1, 1'b1);
        vblank(1'b0);
        px(100, 50);
        step(1);
        chk("addr_tl", rom_addr, 10'h100);
        step(1);
        chk("red_rgb", {vga_r, vga_g, vga_b}, 32'hFF0000);
        px(115, 65);
        step(1);
        chk("addr_br", rom_addr, 10'h1FF);
        px(116, 50);
        step(1);
        chk("addr_hold", rom_addr, 10'h1FF);
        step(1);
        chk("miss_bg", {vga_r, vga_g, vga_b}, 0);

        // Colour expansion, key transparency, blanking
        rom_val = 16'h07E0;  colour_at("green", 100, 50, 24'h00FF00);
        rom_val = 16'h001F;  colour_at("blue", 100, 50, 24'h0000FF);
        rom_val = 16'h8410;  colour_at("mid_grey", 100, 50, 24'h848284);
        rom_val = 16'hF81F;  colour_at("key_bg", 100, 50, 24'h000000);
        rom_val = 16'hF800;
        bright_in = 1'b0;    colour_at("blanked", 100, 50, 24'h000000);
        bright_in = 1'b1;

        // Priority: s0 over s1 at the same spot
        wr_cfg(1, 100, 50, 2, 1'b1);
        vblank(1'b0);
        px(100, 50);
        step(1);
        chk("prio_s0", rom_addr, 10'h100);
        wr_cfg(0, 100, 50, 1, 1'b0);
        vblank(1'b0);
        px(101, 51);
        step(1);
        chk("prio_s1", rom_addr, 10'h211);

        // Mid-frame write is held until the tick
        wr_cfg(1, 200, 50, 2, 1'b1);
        colour_at("midframe_new", 200, 50, 24'h000000);
        colour_at("midframe_old", 100, 50, 24'hFF0000);
        vblank(1'b0);
        px(200, 50);
        step(1);
        chk("moved_addr", rom_addr, 10'h200);
        step(1);
        chk("moved_rgb", {vga_r, vga_g, vga_b}, 32'hFF0000);
        colour_at("old_pos_gone", 100, 50, 24'h000000);

        // Write on the tick cycle takes one extra frame
        set_cfg(1, 300, 50, 2, 1'b1);
        vblank(1'b1);
        colour_at("tickwr_new", 300, 50, 24'h000000);
        colour_at("tickwr_old", 200, 50, 24'hFF0000);
        vblank(1'b0);
        colour_at("tickwr_applied", 300, 50, 24'hFF0000);
        colour_at("tickwr_prev", 200, 50, 24'h000000);

        // Bottom-right corner sprite clips, never wraps
        wr_cfg(2, 630, 470, 3, 1'b1);
        vblank(1'b0);
        px(630, 470);
        step(1);
        chk("edge_addr_tl", rom_addr, 10'h300);
        px(639, 479);
        step(1);
        chk("edge_addr_br", rom_addr, 10'h399);
        step(1);
        chk("edge_rgb", {vga_r, vga_g, vga_b}, 32'hFF0000);
        colour_at("clip_h640", 640, 470, 24'h000000);
        colour_at("nowrap_col0", 0, 470, 24'h000000);
        colour_at("nowrap_line0", 630, 0, 24'h000000);

        // Async reset mid-line, then resume with sprites hidden
        hsync_in = 1'b1;
        vsync_in = 1'b1;
        colour_at("pre_rst_rgb", 639, 479, 24'hFF0000);
        chk("pre_rst_sync", {hsync_out, vsync_out}, 2'b11);
        rst_n = 1'b0;
        #1;
        chk("async_rgb", {vga_r, vga_g, vga_b}, 0);
        chk("async_sync", {hsync_out, vsync_out, bright_out}, 0);
        chk("async_addr", rom_addr, 0);
        step(2);
        rst_n = 1'b1;
        vblank(1'b0);
        colour_at("post_rst_bg", 639, 479, 24'h000000);
        chk("post_rst_bright", bright_out, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
